differentiator_core: RTL

- Inverse of the integrator datapath: recovers input samples from an accumulator stream by first differencing, x = y[n] - y[n-M].
- Leaky mode adds back the decay term, so it exactly undoes a leaky integrator that uses the same decay_shift.
- Sits downstream of the integrator, or on the far end of a link carrying accumulated values. Strobe-edge input, registered saturating output with a valid pulse.

---
 rtl/differentiator_core.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/differentiator_core.sv
// differentiator_core: recovers input samples from an accumulator stream by
// first differencing against a DELAY_M-deep history, optionally adding back
// the leak term so a matching leaky integrator is undone exactly. Samples are
// taken on strobe rising edges; the result is registered, saturated or
// wrapped to OUT_W, and announced with a one-cycle valid pulse.
module differentiator_core #(
  parameter int ACC_W   = 16,
  parameter int OUT_W   = 8,
  parameter int DELAY_M = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    sample_strobe,
  input  logic signed [ACC_W-1:0] acc_in,
  input  logic                    leaky_mode,
  input  logic [7:0]              decay_shift,
  input  logic                    sat_enable,
  input  logic signed [OUT_W-1:0] sat_pos,
  input  logic signed [OUT_W-1:0] sat_neg,
  input  logic                    resync,
  input  logic                    ovf_clear,
  output logic signed [OUT_W-1:0] sample_out,
  output logic                    out_valid,
  output logic                    overflow_flag,
  output logic                    primed
);

  localparam int DW   = ACC_W + 1;
  localparam int HI_I = (2 ** (OUT_W - 1)) - 1;
  localparam logic signed [DW-1:0] LIM_HI = DW'(HI_I);
  localparam logic signed [DW-1:0] LIM_LO = DW'(-HI_I - 1);

  typedef enum logic {
    ST_RUN,
    ST_PRIME
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [2:0]              prime_cnt;
  logic [2:0]              prime_cnt_next;
  logic                    stage_valid;

  logic                    strobe_prev;
  logic                    rise;
  logic                    accept;

  logic signed [ACC_W-1:0] delay_line [DELAY_M];
  logic signed [ACC_W-1:0] oldest;
  logic signed [DW-1:0]    acc_ext;
  logic signed [DW-1:0]    old_ext;
  logic signed [DW-1:0]    corr;
  logic signed [DW-1:0]    diff_now;
  logic [31:0]             k_wide;

  logic signed [DW-1:0]    diff_r;
  logic                    v1;

  logic signed [DW-1:0]    pos_ext;
  logic signed [DW-1:0]    neg_ext;
  logic signed [OUT_W-1:0] out_next;
  logic                    ovf_next;

  assign rise    = sample_strobe & ~strobe_prev;
  assign accept  = enable & rise & ~resync;
  assign primed  = (state == ST_RUN);

  assign oldest  = delay_line[DELAY_M-1];
  assign acc_ext = {acc_in[ACC_W-1], acc_in};
  assign old_ext = {oldest[ACC_W-1], oldest};
  assign k_wide  = {24'd0, decay_shift};
  assign pos_ext = {{(DW-OUT_W){sat_pos[OUT_W-1]}}, sat_pos};
  assign neg_ext = {{(DW-OUT_W){sat_neg[OUT_W-1]}}, sat_neg};

  // Strobe history for rising-edge detection, tracked regardless of enable
  always_ff @(posedge clk) begin
    if (rst) begin
      strobe_prev <= 1'b0;
    end else begin
      strobe_prev <= sample_strobe;
    end
  end

  // Leak correction only exists for shifts smaller than the accumulator width
  always_comb begin
    corr = '0;
    if (leaky_mode && (k_wide < 32'(ACC_W))) begin
      corr = old_ext >>> decay_shift;
    end
    diff_now = acc_ext - old_ext + corr;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      prime_cnt <= '0;
    end else begin
      state     <= state_next;
      prime_cnt <= prime_cnt_next;
    end
  end

  // FSM next state: resync re-primes, priming accepts fill history silently
  always_comb begin
    state_next     = state;
    prime_cnt_next = prime_cnt;
    stage_valid    = 1'b0;
    if (resync) begin
      state_next     = ST_PRIME;
      prime_cnt_next = '0;
    end else if (accept) begin
      if (state == ST_RUN) begin
        stage_valid = 1'b1;
      end else begin
        prime_cnt_next = prime_cnt + 3'd1;
        if (prime_cnt == 3'(DELAY_M - 1)) begin
          state_next = ST_RUN;
        end
      end
    end
  end

  // Delay line holding the last DELAY_M accepted accumulator values
  always_ff @(posedge clk) begin
    if (rst || resync) begin
      for (int i = 0; i < DELAY_M; i++) begin
        delay_line[i] <= '0;
      end
    end else if (accept) begin
      delay_line[0] <= acc_in;
      for (int i = 1; i < DELAY_M; i++) begin
        delay_line[i] <= delay_line[i-1];
      end
    end
  end

  // Stage 1: capture the full-width difference at the accepting edge
  always_ff @(posedge clk) begin
    if (rst) begin
      v1     <= 1'b0;
      diff_r <= '0;
    end else begin
      v1 <= stage_valid;
      if (accept) begin
        diff_r <= diff_now;
      end
    end
  end

  // Stage 2 combinational narrowing: clamp or wrap, flagging out-of-range
  always_comb begin
    out_next = diff_r[OUT_W-1:0];
    ovf_next = 1'b0;
    if (sat_enable) begin
      if (diff_r > pos_ext) begin
        out_next = sat_pos;
        ovf_next = 1'b1;
      end else if (diff_r < neg_ext) begin
        out_next = sat_neg;
        ovf_next = 1'b1;
      end
    end else if ((diff_r > LIM_HI) || (diff_r < LIM_LO)) begin
      ovf_next = 1'b1;
    end
  end

  // Stage 2 register: output sample, valid pulse and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_out    <= '0;
      out_valid     <= 1'b0;
      overflow_flag <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        sample_out <= out_next;
      end
      if (v1 && ovf_next) begin
        overflow_flag <= 1'b1;
      end else if (ovf_clear) begin
        overflow_flag <= 1'b0;
      end
    end
  end

endmodule
